// File: rtl/cla_seq64_ctrl.sv
// Sequential wide adder: one 16-bit carry-lookahead adder reused over WORDS slices.
// Optional subtraction (A-B) is enabled by defining CLA_SEQ_SUBTRACT_EN.

// 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
module cla16_add (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        c_i,
   output logic [15:0] s_o,
   output logic        c_o
);
   logic [15:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [3:0]  gg;
   logic [3:0]  gp;
   logic [4:0]  gc;

   always_comb begin
      g = a_i & b_i;
      p = a_i ^ b_i;
      for (int j = 0; j < 4; j++) begin
         gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gp[j] = &p[4*j +: 4];
      end
      // Group carries resolved in parallel from the group generate/propagate terms.
      gc[0] = c_i;
      gc[1] = gg[0] | (gp[0] & c_i);
      gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_i);
      gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c_i);
      gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
            | (gp[3] & gp[2] & gp[1] & gp[0] & c_i);
      for (int j = 0; j < 4; j++) begin
         c[4*j]   = gc[j];
         c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
         c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
         c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                  | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
      end
      s_o = p ^ c;
      c_o = gc[4];
   end
endmodule

module cla_seq64_ctrl #(
   parameter int unsigned WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inValid,
   output logic                  inReady,
   input  logic [16*WORDS-1:0]   operA,
   input  logic [16*WORDS-1:0]   operB,
   input  logic                  Cin,
`ifdef CLA_SEQ_SUBTRACT_EN
   input  logic                  sub,
`endif
   output logic                  outValid,
   input  logic                  outReady,
   output logic [16*WORDS-1:0]   resultOUT,
   output logic                  Cout,
   output logic                  busy
);
   localparam int unsigned W     = 16 * WORDS;
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic [W-1:0]     result_q;
   logic [IDX_W-1:0] slice_q;
   logic             carry_q;
   logic             cout_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;
   logic             sub_q;
   logic             sub_in;

   logic [15:0]      add_a;
   logic [15:0]      add_b;
   logic [15:0]      add_s;
   logic             add_co;

`ifdef CLA_SEQ_SUBTRACT_EN
   assign sub_in = sub;
`else
   assign sub_in = 1'b0;
`endif

   // Select the active slice; subtraction inverts B here and seeds carry with 1 on accept.
   always_comb begin
      add_a = a_q[{slice_q, 4'b0000} +: 16];
      add_b = b_q[{slice_q, 4'b0000} +: 16] ^ {16{sub_q}};
   end

   cla16_add u_cla (
      .a_i (add_a),
      .b_i (add_b),
      .c_i (carry_q),
      .s_o (add_s),
      .c_o (add_co)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         slice_q     <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         sub_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (inValid) begin
                  a_q        <= operA;
                  b_q        <= operB;
                  sub_q      <= sub_in;
                  carry_q    <= sub_in ? 1'b1 : Cin;
                  slice_q    <= '0;
                  state_q    <= RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            RUN: begin
               result_q[{slice_q, 4'b0000} +: 16] <= add_s;
               carry_q <= add_co;
               if (slice_q == IDX_W'(WORDS - 1)) begin
                  slice_q     <= '0;
                  cout_q      <= add_co;
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  slice_q <= slice_q + IDX_W'(1);
               end
            end
            DONE: begin
               if (outReady) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign inReady   = in_ready_q;
   assign outValid  = out_valid_q;
   assign resultOUT = result_q;
   assign Cout      = cout_q;
   assign busy      = busy_q;
endmodule
